// File: rtl/elixirchip_es1_spu_op_mac.sv
// rtl/elixirchip_es1_spu_op_mac.sv - pipelined multiply-accumulate with clear/subtract, shift and saturate/truncate output
module elixirchip_es1_spu_op_mac #(
  parameter int LATENCY      = 4,
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 8,
  parameter int SIGNED0      = 1,
  parameter int SIGNED1      = 1,
  parameter int ACC_BITS     = 48,
  parameter int M_DATA_BITS  = 32,
  parameter int DATA_SHIFT   = 0,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cke,
  input  logic [S_DATA0_BITS-1:0] s_data0,
  input  logic [S_DATA1_BITS-1:0] s_data1,
  input  logic                    s_clear,
  input  logic                    s_sub,
  input  logic                    s_valid,
  output logic [M_DATA_BITS-1:0]  m_data,
  output logic                    m_ovf,
  output logic                    m_valid
);

  // One extra bit per operand carries the chosen extension, so the product is exact for any signedness mix
  localparam int PW = S_DATA0_BITS + S_DATA1_BITS + 2;
  localparam int DL = LATENCY - 4;
  localparam logic [M_DATA_BITS-1:0] MAX_POS = {1'b0, {(M_DATA_BITS-1){1'b1}}};
  localparam logic [M_DATA_BITS-1:0] MIN_NEG = ~MAX_POS;

  logic [S_DATA0_BITS-1:0] st0_data0;
  logic [S_DATA1_BITS-1:0] st0_data1;
  logic                    st0_clear, st0_sub, st0_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st0_data0 <= '0;
      st0_data1 <= '0;
      st0_clear <= 1'b0;
      st0_sub   <= 1'b0;
      st0_valid <= 1'b0;
    end else if (cke) begin
      st0_data0 <= s_data0;
      st0_data1 <= s_data1;
      st0_clear <= s_clear;
      st0_sub   <= s_sub;
      st0_valid <= s_valid;
    end
  end

  logic signed [S_DATA0_BITS:0] ext0;
  logic signed [S_DATA1_BITS:0] ext1;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_BITS-1:0]   prod_acc;

  always_comb begin
    ext0     = {(SIGNED0 != 0) & st0_data0[S_DATA0_BITS-1], st0_data0};
    ext1     = {(SIGNED1 != 0) & st0_data1[S_DATA1_BITS-1], st0_data1};
    prod     = PW'(ext0) * PW'(ext1);
    prod_acc = ACC_BITS'(prod);
  end

  logic signed [ACC_BITS-1:0] st1_prod;
  logic                       st1_clear, st1_sub, st1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st1_prod  <= '0;
      st1_clear <= 1'b0;
      st1_sub   <= 1'b0;
      st1_valid <= 1'b0;
    end else if (cke) begin
      st1_prod  <= prod_acc;
      st1_clear <= st0_clear;
      st1_sub   <= st0_sub;
      st1_valid <= st0_valid;
    end
  end

  logic signed [ACC_BITS-1:0] acc, addend, acc_next;
  logic                       st2_valid;

  always_comb begin
    addend   = st1_sub ? -st1_prod : st1_prod;
    acc_next = st1_clear ? addend : acc + addend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      st2_valid <= 1'b0;
    end else if (cke) begin
      if (st1_valid) acc <= acc_next;
      st2_valid <= st1_valid;
    end
  end

  // Overflow means the bits above the output sign bit are not all copies of it
  logic signed [ACC_BITS-1:0]      shifted;
  logic [ACC_BITS-M_DATA_BITS:0]   hi;
  logic                            res_ovf;
  logic [M_DATA_BITS-1:0]          res_data;

  always_comb begin
    shifted  = acc >>> DATA_SHIFT;
    hi       = shifted[ACC_BITS-1:M_DATA_BITS-1];
    res_ovf  = !((&hi) || !(|hi));
    res_data = shifted[M_DATA_BITS-1:0];
    if (SATURATE != 0 && res_ovf)
      res_data = shifted[ACC_BITS-1] ? MIN_NEG : MAX_POS;
  end

  logic [M_DATA_BITS-1:0] st3_data;
  logic                   st3_ovf, st3_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st3_data  <= '0;
      st3_ovf   <= 1'b0;
      st3_valid <= 1'b0;
    end else if (cke) begin
      if (st2_valid) begin
        st3_data <= res_data;
        st3_ovf  <= res_ovf;
      end
      st3_valid <= st2_valid;
    end
  end

  generate
    if (DL == 0) begin : g_nodelay
      assign m_data  = st3_data;
      assign m_ovf   = st3_ovf;
      assign m_valid = st3_valid;
    end else begin : g_delay
      logic [M_DATA_BITS-1:0] dl_data  [DL];
      logic                   dl_ovf   [DL];
      logic                   dl_valid [DL];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DL; i++) begin
            dl_data[i]  <= '0;
            dl_ovf[i]   <= 1'b0;
            dl_valid[i] <= 1'b0;
          end
        end else if (cke) begin
          dl_data[0]  <= st3_data;
          dl_ovf[0]   <= st3_ovf;
          dl_valid[0] <= st3_valid;
          for (int i = 1; i < DL; i++) begin
            dl_data[i]  <= dl_data[i-1];
            dl_ovf[i]   <= dl_ovf[i-1];
            dl_valid[i] <= dl_valid[i-1];
          end
        end
      end

      assign m_data  = dl_data[DL-1];
      assign m_ovf   = dl_ovf[DL-1];
      assign m_valid = dl_valid[DL-1];
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mac.sv
// tb/tb_elixirchip_es1_spu_op_mac.sv - directed-vector bench for the MAC across several parameter sets
module tb_elixirchip_es1_spu_op_mac;

  logic       clk = 1'b0;
  logic       reset, cke;
  logic [7:0] s_data0, s_data1;
  logic       s_clear, s_sub, s_valid;

  logic [31:0] d_def, d_lat7, d_uns, d_uns4;
  logic [7:0]  d_sat, d_trn;
  logic        o_def, o_lat7, o_sat, o_trn, o_uns, o_uns4;
  logic        v_def, v_lat7, v_sat, v_trn, v_uns, v_uns4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_mac u_def (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_sub(s_sub), .s_valid(s_valid),
    .m_data(d_def), .m_ovf(o_def), .m_valid(v_def));

  elixirchip_es1_spu_op_mac #(.LATENCY(7)) u_lat7 (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_sub(s_sub), .s_valid(s_valid),
    .m_data(d_lat7), .m_ovf(o_lat7), .m_valid(v_lat7));

  elixirchip_es1_spu_op_mac #(.M_DATA_BITS(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_sub(s_sub), .s_valid(s_valid),
    .m_data(d_sat), .m_ovf(o_sat), .m_valid(v_sat));

  elixirchip_es1_spu_op_mac #(.M_DATA_BITS(8), .SATURATE(0)) u_trn (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_sub(s_sub), .s_valid(s_valid),
    .m_data(d_trn), .m_ovf(o_trn), .m_valid(v_trn));

  elixirchip_es1_spu_op_mac #(.SIGNED0(0), .SIGNED1(0)) u_uns (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_sub(s_sub), .s_valid(s_valid),
    .m_data(d_uns), .m_ovf(o_uns), .m_valid(v_uns));

  elixirchip_es1_spu_op_mac #(.SIGNED0(0), .SIGNED1(0), .DATA_SHIFT(4)) u_uns4 (
    .clk(clk), .reset(reset), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
    .s_clear(s_clear), .s_sub(s_sub), .s_valid(s_valid),
    .m_data(d_uns4), .m_ovf(o_uns4), .m_valid(v_uns4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input int b, input logic clr, input logic sub);
    s_data0 = 8'(a);
    s_data1 = 8'(b);
    s_clear = clr;
    s_sub   = sub;
    s_valid = 1'b1;
    tick();
  endtask

  // Idle cycles carry junk data and clear/sub set, which must all be ignored
  task automatic idle();
    s_data0 = 8'h5A;
    s_data1 = 8'hA5;
    s_clear = 1'b1;
    s_sub   = 1'b1;
    s_valid = 1'b0;
    tick();
  endtask

  int exp_d5[6]  = '{5, 14, 30, 0, 0, 0};
  int exp_v5[6]  = '{1, 1, 1, 0, 0, 0};
  int exp_l5[6]  = '{0, 0, 1, 5, 14, 30};
  int exp_lv5[6] = '{0, 0, 1, 1, 1, 1};

  initial begin
    reset = 1'b1; cke = 1'b1;
    s_data0 = '0; s_data1 = '0; s_clear = 1'b0; s_sub = 1'b0; s_valid = 1'b0;
    #12;
    chk("rst_valid", 32'(v_def), 32'd0);
    chk("rst_data", d_def, 32'd0);
    chk("rst_ovf", 32'(o_def), 32'd0);
    chk("rst_lat7_valid", 32'(v_lat7), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    put(3, 4, 1, 0); put(5, -2, 0, 0); put(-7, 1, 0, 0);
    idle(); chk("t1_v0", 32'(v_def), 32'd1); chk("t1_d0", d_def, 32'd12); chk("t1_lat7_early", 32'(v_lat7), 32'd0);
    idle(); chk("t1_d1", d_def, 32'd2);
    idle(); chk("t1_d2", d_def, -32'sd5);
    idle(); chk("t1_v_end", 32'(v_def), 32'd0); chk("t1_lat7_v", 32'(v_lat7), 32'd1); chk("t1_lat7_d0", d_lat7, 32'd12);
    idle(); chk("t1_lat7_d1", d_lat7, 32'd2);
    idle(); chk("t1_lat7_d2", d_lat7, -32'sd5); chk("t1_lat7_ovf", 32'(o_lat7), 32'd0);

    put(3, 3, 1, 0); idle(); idle(); put(1, 1, 0, 0);
    chk("hold_d0", d_def, 32'd9);
    idle(); chk("hold_gap1", 32'(v_def), 32'd0);
    idle(); chk("hold_gap2", 32'(v_def), 32'd0);
    idle(); chk("hold_d1", d_def, 32'd10); chk("hold_v1", 32'(v_def), 32'd1);

    put(10, 10, 1, 1); put(2, 3, 0, 0); idle();
    idle(); chk("sub_d0", d_def, -32'sd100);
    idle(); chk("sub_d1", d_def, -32'sd94);

    put(127, 127, 1, 0); put(127, 127, 0, 0); put(127, 127, 0, 0);
    idle(); chk("sat_d0", 32'(d_sat), 32'h7F); chk("sat_o0", 32'(o_sat), 32'd1); chk("sat_v0", 32'(v_sat), 32'd1);
    chk("trn_d0", 32'(d_trn), 32'h01); chk("trn_o0", 32'(o_trn), 32'd1);
    idle(); chk("trn_d1", 32'(d_trn), 32'h02);
    idle(); chk("trn_d2", 32'(d_trn), 32'h03); chk("trn_v2", 32'(v_trn), 32'd1); chk("sat_d2", 32'(d_sat), 32'h7F);

    put(127, 1, 1, 0); put(64, 2, 1, 0); put(-128, 1, 1, 0);
    idle(); chk("edge127_sat", 32'(d_sat), 32'h7F); chk("edge127_sat_o", 32'(o_sat), 32'd0);
    chk("edge127_trn", 32'(d_trn), 32'h7F); chk("edge127_trn_o", 32'(o_trn), 32'd0);
    idle(); chk("edge128_sat", 32'(d_sat), 32'h7F); chk("edge128_sat_o", 32'(o_sat), 32'd1);
    chk("edge128_trn", 32'(d_trn), 32'h80); chk("edge128_trn_o", 32'(o_trn), 32'd1);
    idle(); chk("edgem128_sat", 32'(d_sat), 32'h80); chk("edgem128_sat_o", 32'(o_sat), 32'd0);
    chk("edgem128_trn", 32'(d_trn), 32'h80); chk("edgem128_trn_o", 32'(o_trn), 32'd0);

    put(255, 255, 1, 0); idle(); idle();
    idle(); chk("uns_d", d_uns, 32'd65025); chk("uns_o", 32'(o_uns), 32'd0); chk("uns_v", 32'(v_uns), 32'd1);
    chk("uns4_d", d_uns4, 32'd4064); chk("uns4_o", 32'(o_uns4), 32'd0); chk("uns4_v", 32'(v_uns4), 32'd1);

    put(1, 1, 1, 0); put(2, 2, 0, 0); put(3, 3, 0, 0); put(4, 4, 0, 0);
    chk("cke_d_pre", d_def, 32'd1);
    cke = 1'b0; s_valid = 1'b1; s_data0 = 8'd9; s_data1 = 8'd9; s_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cke_hold_d", d_def, 32'd1);
      chk("cke_hold_v", 32'(v_def), 32'd1);
      chk("cke_hold_lat7_v", 32'(v_lat7), 32'd0);
    end
    cke = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("cke_resume_v", 32'(v_def), 32'(exp_v5[i]));
      if (exp_v5[i] != 0) chk("cke_resume_d", d_def, 32'(exp_d5[i]));
      chk("cke_lat7_v", 32'(v_lat7), 32'(exp_lv5[i]));
      if (exp_lv5[i] != 0) chk("cke_lat7_d", d_lat7, 32'(exp_l5[i]));
    end

    put(5, 5, 1, 0); put(5, 5, 0, 0); put(5, 5, 0, 0);
    idle(); chk("rst_mid_pre", d_def, 32'd25);
    #2; reset = 1'b1;
    #1; chk("rst_async_d", d_def, 32'd0); chk("rst_async_v", 32'(v_def), 32'd0);
    chk("rst_async_o", 32'(o_def), 32'd0); chk("rst_async_lat7_d", d_lat7, 32'd0);
    #1; reset = 1'b0;
    put(2, 2, 0, 0); idle();
    idle(); chk("rst_no_inflight", 32'(v_def), 32'd0);
    idle(); chk("rst_after_d", d_def, 32'd4); chk("rst_after_v", 32'(v_def), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
